ysyx_23060171_exu_ctrl: RTL

//  Valid/ready sequencer wrapped around the combinational EXU datapath, between IDU and ISU.

---
 rtl/ysyx_23060171_exu_pkg.sv | 24 ++
 rtl/ysyx_23060171_mdu_iter.sv | 94 +++++++++
 rtl/ysyx_23060171_exu_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/ysyx_23060171_exu_pkg.sv
// Shared types for the EXU valid/ready sequencer and its iterative MDU.
// Build with YSYX_23060171_MDU_EN defined to include the M-extension unit.
package ysyx_23060171_exu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      HOLD
   } state_e;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   localparam int MDU_STEPS = 32;

endpackage

// File: rtl/ysyx_23060171_mdu_iter.sv
// Radix-2 iterative multiply/divide: shift-add MUL, restoring DIV on
// magnitudes, sign fix-up folded into the last step.
module ysyx_23060171_mdu_iter
   import ysyx_23060171_exu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            step,
   input  logic            last,
   output logic            done,
   output logic [XLEN-1:0] result
);

   mdu_op_e             op_in, op_q;
   logic [XLEN:0]       hi, hi_n, sum, rem_sh;
   logic [XLEN-1:0]     lo, lo_n, den;
   logic [XLEN-1:0]     a_mag, b_mag, quo, rem, fix;
   logic [XLEN+1:0]     diff;
   logic [2*XLEN-1:0]   prod, prod_s;
   logic                a_neg, b_neg, neg_q, neg_r, dz, ge;

   always_comb begin
      op_in = mdu_op_e'(op);
      a_neg = a[XLEN-1] &&
              (op_in inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
      b_neg = b[XLEN-1] &&
              (op_in inside {MDU_MULH, MDU_DIV, MDU_REM});
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   // hi/lo is {accumulator, multiplier} for MUL, {remainder, quotient} for DIV
   always_comb begin
      sum    = hi + (lo[0] ? {1'b0, den} : '0);
      rem_sh = {hi[XLEN-1:0], lo[XLEN-1]};
      diff   = {1'b0, rem_sh} - {2'b0, den};
      ge     = !diff[XLEN+1];
      if (op_q[2]) begin
         hi_n = ge ? diff[XLEN:0] : rem_sh;
         lo_n = {lo[XLEN-2:0], ge};
      end else begin
         hi_n = {1'b0, sum[XLEN:1]};
         lo_n = {sum[0], lo[XLEN-1:1]};
      end
      prod   = {hi_n[XLEN-1:0], lo_n};
      prod_s = neg_q ? -prod : prod;
      quo    = dz ? '1 : (neg_q ? -lo_n : lo_n);
      rem    = neg_r ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
      unique case (op_q)
         MDU_MUL:                      fix = prod_s[XLEN-1:0];
         MDU_MULH, MDU_MULHSU,
         MDU_MULHU:                    fix = prod_s[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:            fix = quo;
         default:                      fix = rem;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         op_q   <= MDU_MUL;
         hi     <= '0;
         lo     <= '0;
         den    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else if (start) begin
         op_q  <= op_in;
         hi    <= '0;
         lo    <= a_mag;
         den   <= b_mag;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         dz    <= (b == '0);
         done  <= 1'b0;
      end else if (step) begin
         hi <= hi_n;
         lo <= lo_n;
         if (last) begin
            result <= fix;
            done   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ysyx_23060171_exu_ctrl.sv
// Valid/ready sequencer around the EXU; M-ext ops run on the iterative
// MDU only when YSYX_23060171_MDU_EN is defined.
module ysyx_23060171_exu_ctrl
   import ysyx_23060171_exu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int PAYLOAD_W = 128
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_is_mdu,
   input  logic [2:0]           in_mdu_op,
   input  logic [XLEN-1:0]      in_a,
   input  logic [XLEN-1:0]      in_b,
   input  logic [XLEN-1:0]      in_alu_result,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_result,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic                 busy
);

   state_e          state, state_n;
   logic [4:0]      counter;
   logic            accept, go_mdu, mdu_done;
   logic [XLEN-1:0] mdu_result;

   assign in_ready  = !flush &&
                      (state == IDLE || (state == HOLD && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == HOLD);

`ifdef YSYX_23060171_MDU_EN
   assign go_mdu = in_is_mdu;
   assign busy   = (state == BUSY);

   ysyx_23060171_mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clock  (clock),
      .resetn (resetn),
      .start  (accept && go_mdu),
      .op     (in_mdu_op),
      .a      (in_a),
      .b      (in_b),
      .step   (state == BUSY && !mdu_done),
      .last   (counter == 5'd0),
      .done   (mdu_done),
      .result (mdu_result)
   );
`else
   logic unused_mdu;
   assign unused_mdu = ^{in_is_mdu, in_mdu_op, in_a, in_b};
   assign go_mdu     = 1'b0;
   assign busy       = 1'b0;
   assign mdu_done   = 1'b0;
   assign mdu_result = '0;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: if (accept) state_n = go_mdu ? BUSY : HOLD;
            BUSY: if (mdu_done) state_n = HOLD;
            HOLD: if (out_ready)
                     state_n = !accept ? IDLE : (go_mdu ? BUSY : HOLD);
            default: state_n = IDLE;
         endcase
      end
   end

   // The done cycle writes the result, so HOLD lands one edge after the last step
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         counter     <= '0;
         out_result  <= '0;
         out_payload <= '0;
      end else if (flush) begin
         counter <= '0;
      end else if (accept) begin
         out_payload <= in_payload;
         if (go_mdu) counter    <= 5'(MDU_STEPS - 1);
         else        out_result <= in_alu_result;
      end else if (state == BUSY) begin
         if (mdu_done)              out_result <= mdu_result;
         else if (counter != 5'd0)  counter    <= counter - 5'd1;
      end
   end

endmodule
